fixed_float_pipe: RTL and testbench
===================================

Name: fixed_float_pipe

Overview:
- Pipelined, parametrised Q(M,N) fixed-point to IEEE-754 single-precision converter.
- Successor to the combinational Fixed_Float block. Adds a 3-stage pipeline, a valid/ready handshake with backpressure, run-time signed/unsigned selection and run-time rounding mode.
- Sits between fixed-point DSP datapaths and float consumers (logging, host interface).

Parameters:
- M, 16, integer bits of the input Q(M,N) word (sign bit included when signed); 1 ≤ M.
- N, 16, fractional bits; 0 ≤ N ≤ 64; constraint 2 ≤ M+N ≤ 64. Elaboration error if violated.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- fixed_in  in  M+N  Q(M,N) input word.
- signed_mode  in  1  1 = fixed_in is two's complement; 0 = unsigned. Sampled with fixed_in.
- rnd_mode  in  1  0 = round-to-nearest-even; 1 = truncate toward zero. Sampled with fixed_in.
- out_valid  out  1  float_out valid.
- out_ready  in  1  consumer accepts output.
- float_out  out  32  IEEE-754 single result.

Behaviour:
- Reset (async, active-high):
  - All stage valids, out_valid and float_out are cleared to 0.
  - In-flight data is discarded.
  - After release, in_ready = 1.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Advance and stall:
  - Pipeline advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - All stages advance together on adv. When adv = 0, every stage register holds.
  - float_out stays stable while out_valid && !out_ready.
- Latency and throughput:
  - Latency is exactly 3 clk edges from input transfer to out_valid, with out_ready held high.
  - Throughput is 1 word per cycle.
  - Bubbles propagate as valid = 0 and are squeezed out by backpressure.
- Stage 1 (sign/magnitude):
  - sign = signed_mode & fixed_in[M+N-1].
  - mag = |value| at width M+N+1. The most negative signed value (e.g. 0x80000000 for Q16.16) yields 2^(M+N-1) with no overflow.
- Stage 2 (normalise):
  - Leading-one detect gives position p of mag's MSB.
  - Left-normalise so the MSB sits at a fixed position.
  - Retain 24 significand bits, a guard bit, and a sticky OR of all lower bits.
- Stage 3 (round and pack):
  - RNE: increment when guard && (sticky || lsb).
  - Truncate: never increment.
  - If rounding carries out of the significand, shift right 1 and exponent +1.
  - exponent = 127 + p − N. The M+N ≤ 64 and N ≤ 64 bounds guarantee no float overflow or denormal; no saturation logic is needed.
- Zero:
  - mag = 0 yields float_out = 0x00000000 for either signed_mode.
  - −0 is never produced.
- Exactness:
  - Values with p < 24 are exact; guard = sticky = 0.
- Mode sampling:
  - signed_mode and rnd_mode are registered with the data word.
  - Changing them between words affects only subsequently accepted words.

Optional Feature:
- Macro FIXED_FLOAT_INEXACT_EN.
- When defined:
  - Adds output port out_inexact (1 bit), pipelined alongside float_out.
  - out_inexact = guard | sticky for that word, independent of rnd_mode.
  - Held stable under backpressure; reset value 0.
- When undefined:
  - The port does not exist.
  - No guard/sticky pipeline register is kept beyond what rounding needs.

Test Plan (M=16, N=16):
1. Basic conversions, signed_mode = 1, rnd_mode = 0, out_ready = 1. Back-to-back words 0x0003C000, 0xFFFD8000, 0x00000000, 0x00010000 → 0x40700000, 0xC0200000, 0x00000000, 0x3F800000. Each appears exactly 3 cycles after its input, on consecutive cycles.
2. Extremes:
   - signed 0x80000000 → 0xC7000000.
   - unsigned 0x80000000 → 0x47000000.
   - signed 0x00000001 → 0x37800000.
3. Rounding, unsigned 0xFFFFFFFF:
   - rnd_mode = 0 → 0x47800000 (carry increments exponent).
   - rnd_mode = 1 → 0x477FFFFF.
4. Ties, unsigned, rnd_mode = 0:
   - 0x02000002 → 0x44000000 (tie, LSB even, no round).
   - 0x02000006 → 0x44000002 (tie, round up).
   - 0x02000006 with rnd_mode = 1 → 0x44000001.
   - With FIXED_FLOAT_INEXACT_EN: out_inexact = 1 for all three; 0 for 0x00010000.
5. Backpressure:
   - Stream 6 words; drop out_ready for 4 cycles after the first out_valid.
   - float_out must be stable while stalled and in_ready = 0 during the stall.
   - All 6 results arrive in order with no loss or duplication.
6. Reset mid-stream:
   - Assert rst asynchronously (between clock edges) with 3 words in flight.
   - out_valid = 0 and float_out = 0 immediately.
   - No stale word emerges after release; the next accepted word appears 3 cycles later.

Source files
------------

// File: rtl/fixed_float_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_float_pipe: 3-stage Q(M,N) fixed-point to IEEE-754 single converter |
// | Optional FIXED_FLOAT_INEXACT_EN adds out_inexact. Revision: 1.0           |
// +--------------------------------------------------------------------------+
module fixed_float_pipe #(
  parameter int M = 16,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M+N-1:0] fixed_in,
  input  logic           signed_mode,
  input  logic           rnd_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    float_out
`ifdef FIXED_FLOAT_INEXACT_EN
  ,
  output logic           out_inexact
`endif
);

  localparam int W  = M + N;
  localparam int MW = W + 1;
  localparam int XW = MW + 25;

  if (M < 1 || N < 0 || N > 64 || W < 2 || W > 64) begin : g_param_check
    $error("fixed_float_pipe: illegal M/N combination");
  end

  logic          adv;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q, s1_sign_d;
  logic          s1_rnd_q, s1_rnd_d;
  logic [MW-1:0] s1_mag_q, s1_mag_d;

  logic          s2_valid_q, s2_valid_d;
  logic          s2_sign_q, s2_sign_d;
  logic          s2_zero_q, s2_zero_d;
  logic          s2_inc_q, s2_inc_d;
  logic [7:0]    s2_exp_q, s2_exp_d;
  logic [22:0]   s2_frac_q, s2_frac_d;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   float_out_q, float_out_d;

  logic [MW-1:0] mag_abs;
  int            p;
  logic [XW-1:0] norm;
  logic          guard, sticky;
  logic [23:0]   frac_sum;

`ifdef FIXED_FLOAT_INEXACT_EN
  logic          s2_inexact_q, s2_inexact_d;
  logic          out_inexact_q, out_inexact_d;
`endif

  assign adv = !out_valid_q || out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_rnd_d    = s1_rnd_q;
    s1_mag_d    = s1_mag_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_inc_d    = s2_inc_q;
    s2_exp_d    = s2_exp_q;
    s2_frac_d   = s2_frac_q;
    out_valid_d = out_valid_q;
    float_out_d = float_out_q;
`ifdef FIXED_FLOAT_INEXACT_EN
    s2_inexact_d  = s2_inexact_q;
    out_inexact_d = out_inexact_q;
`endif

    // Stage 1: magnitude one bit wider so the most negative value fits
    if (signed_mode && fixed_in[W-1]) begin
      mag_abs = {1'b0, ~fixed_in} + MW'(1);
    end else begin
      mag_abs = {1'b0, fixed_in};
    end

    // Stage 2: MSB lands at the top of norm; 25 zero pad bits cover small words
    p = 0;
    for (int i = 0; i < MW; i++) begin
      if (s1_mag_q[i]) begin
        p = i;
      end
    end
    norm   = {s1_mag_q, 25'b0} << (MW - 1 - p);
    guard  = norm[XW-25];
    sticky = |norm[XW-26:0];

    // Stage 3: carry out of an all-ones fraction wraps it to zero and bumps the exponent
    frac_sum = {1'b0, s2_frac_q} + {23'b0, s2_inc_q};

    if (adv) begin
      s1_valid_d  = in_valid;
      s1_sign_d   = signed_mode & fixed_in[W-1];
      s1_rnd_d    = rnd_mode;
      s1_mag_d    = mag_abs;

      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = ~norm[XW-1];
      s2_frac_d   = norm[XW-2 -: 23];
      s2_exp_d    = 8'(127 + p - N);
      s2_inc_d    = ~s1_rnd_q & guard & (sticky | norm[XW-24]);

      out_valid_d = s2_valid_q;
      float_out_d = s2_zero_q ? 32'h0000_0000
                              : {s2_sign_q, s2_exp_q + {7'b0, frac_sum[23]}, frac_sum[22:0]};
`ifdef FIXED_FLOAT_INEXACT_EN
      s2_inexact_d  = guard | sticky;
      out_inexact_d = s2_inexact_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_rnd_q    <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_inc_q    <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      out_valid_q <= 1'b0;
      float_out_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_inc_q    <= s2_inc_d;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      out_valid_q <= out_valid_d;
      float_out_q <= float_out_d;
    end
  end

`ifdef FIXED_FLOAT_INEXACT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_inexact_q  <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      s2_inexact_q  <= s2_inexact_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_inexact = out_inexact_q;
`endif

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign float_out = float_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_float_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fixed_float_pipe: randomized + directed bench for fixed_float_pipe     |
// | Honours FIXED_FLOAT_INEXACT_EN when defined. Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_fixed_float_pipe;

  localparam int M = 16;
  localparam int N = 16;
  localparam int W = M + N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  fixed_in = '0;
  logic          signed_mode = 1'b0;
  logic          rnd_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   float_out;
`ifdef FIXED_FLOAT_INEXACT_EN
  logic          out_inexact;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rx     = 0;
  bit lat_chk  = 1'b0;

  typedef struct {
    logic [31:0] f;
    bit          inx;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_float_pipe #(.M(M), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fixed_in    (fixed_in),
    .signed_mode (signed_mode),
    .rnd_mode    (rnd_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .float_out   (float_out)
`ifdef FIXED_FLOAT_INEXACT_EN
    ,
    .out_inexact (out_inexact)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: exact integer magnitude, then divide/remainder rounding
  task automatic ref_model(input logic [W-1:0] x, input bit sm, input bit rm,
                           output logic [31:0] f, output bit inx);
    longint unsigned mag, q, rem, half;
    int p, sh, ex;
    bit s;
    s   = sm && x[W-1];
    mag = s ? ((64'd1 << W) - 64'(x)) : 64'(x);
    f   = 32'h0;
    inx = 1'b0;
    if (mag != 0) begin
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      rem = 0;
      if (p <= 23) begin
        q = mag << (23 - p);
      end else begin
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 64'd1 << (sh - 1);
        if (!rm && (rem > half || (rem == half && q[0]))) q++;
      end
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
      ex  = 127 + p - N;
      f   = {s, ex[7:0], q[22:0]};
      inx = (rem != 0);
    end
  endtask

  // Drive one word and hold it until accepted; use_k overrides the model result
  task automatic send(input logic [W-1:0] x, input bit sm, input bit rm,
                      input bit use_k = 1'b0, input logic [31:0] fk = 32'h0);
    exp_t e;
    bit   acc;
    int   tries;
    fixed_in    = x;
    signed_mode = sm;
    rnd_mode    = rm;
    in_valid    = 1'b1;
    ref_model(x, sm, rm, e.f, e.inx);
    if (use_k) e.f = fk;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc   = in_ready;
      e.cyc = cyc;
      @(posedge clk);
      #1;
      tries++;
    end
    if (acc) exp_q.push_back(e);
    else check_eq("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard, latency, stall stability
  initial begin
    exp_t        e;
    bit          stalled;
    logic [31:0] held_f;
    stalled = 1'b0;
    held_f  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check_eq("stall_valid", 64'(out_valid), 64'd1);
          check_eq("stall_hold", 64'(float_out), 64'(held_f));
        end
        if (out_valid && !out_ready) check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          n_rx++;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("float_out", 64'(float_out), 64'(e.f));
`ifdef FIXED_FLOAT_INEXACT_EN
            check_eq("out_inexact", 64'(out_inexact), 64'(e.inx));
`endif
            if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'd3);
          end
        end
        stalled = out_valid && !out_ready;
        held_f  = float_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rx0;
    int  t;
    bit  done;
    logic [W-1:0] x;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_float_out", 64'(float_out), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic back-to-back conversions with exact latency
    lat_chk = 1'b1;
    send(32'h0003C000, 1, 0, 1, 32'h40700000);
    send(32'hFFFD8000, 1, 0, 1, 32'hC0200000);
    send(32'h00000000, 1, 0, 1, 32'h00000000);
    send(32'h00010000, 1, 0, 1, 32'h3F800000);
    in_valid = 1'b0;
    drain();

    // Extremes, rounding carry, ties
    send(32'h80000000, 1, 0, 1, 32'hC7000000);
    send(32'h80000000, 0, 0, 1, 32'h47000000);
    send(32'h00000001, 1, 0, 1, 32'h37800000);
    send(32'hFFFFFFFF, 0, 0, 1, 32'h47800000);
    send(32'hFFFFFFFF, 0, 1, 1, 32'h477FFFFF);
    send(32'h02000002, 0, 0, 1, 32'h44000000);
    send(32'h02000006, 0, 0, 1, 32'h44000002);
    send(32'h02000006, 0, 1, 1, 32'h44000001);
    send(32'h00000000, 0, 0, 1, 32'h00000000);
    send(32'h00010000, 0, 0, 1, 32'h3F800000);
    in_valid = 1'b0;
    drain();

    // Backpressure: 6 words, out_ready low for 4 cycles after first out_valid
    lat_chk = 1'b0;
    rx0 = n_rx;
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        check_eq("bp_first_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", 64'(n_rx - rx0), 64'd6);

    // Randomized traffic with random gaps and random backpressure
    done = 1'b0;
    rx0  = n_rx;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          x = W'($urandom);
          case ($urandom_range(0, 7))
            0: x = 32'h80000000;
            1, 2: x = x >> $urandom_range(0, 31);
            default: ;
          endcase
          send(x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("rand_count", 64'(n_rx - rx0), 64'd80);

    // Asynchronous reset with words in flight
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) send(W'(32'h00010000 * (i + 2)), 1, 0);
    in_valid = 1'b0;
    #3;
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_float", 64'(float_out), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'hFFFF0000, 1, 0, 1, 32'hBF800000);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
